// File: rtl/read_data_collector.sv
// Paces the array read FSM one word at a time, buffers returns in an FWFT FIFO and streams them out.
// Optional read-return timeout is enabled by defining READ_TIMEOUT_EN.
module read_data_collector #(
  parameter int unsigned DATA_W      = 9,
  parameter int unsigned ADDR_W      = 21,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  burst_len,
  output logic              rden,
  input  logic              rd_request,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic              err_spurious,
  output logic              timeout
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;

  generate
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_param
      $error("read_data_collector: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYC >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, DRAIN} state_t;

  typedef struct packed {
    logic              last;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t            state_q, state_d;
  entry_t            mem [FIFO_DEPTH];
  entry_t            head;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [CNT_W-1:0]  len_q, issued_q;
  logic              rden_q, done_q, err_q, busy_q;
  logic              rden_d, done_d, err_d;
  logic              fifo_empty, fifo_room, req_ok, is_last, push, pop, timeout_hit;

  assign fifo_empty = (occ_q == '0);
  assign fifo_room  = (occ_q < OCC_W'(FIFO_DEPTH));
  assign req_ok     = (state_q == WAIT_DATA) && rd_request;
  assign is_last    = (CNT_W'(issued_q + CNT_W'(1)) == len_q);
  assign push       = req_ok && fifo_room;
  assign pop        = !fifo_empty && m_ready;
  assign occ_d      = OCC_W'(occ_q + OCC_W'(push) - OCC_W'(pop));

`ifdef READ_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt_q;
  logic             timeout_q;

  assign timeout_hit = (state_q == WAIT_DATA) && !rd_request &&
                       (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Wait counter is held at zero outside WAIT_DATA so it restarts on every entry.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= (state_q == WAIT_DATA) ? CNT_W'(wait_cnt_q + CNT_W'(1)) : '0;
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout     = 1'b0;
`endif

  // State register
  always_ff @(posedge sys_clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start && burst_len != '0) state_d = ISSUE;
      ISSUE:     if (fifo_room) state_d = WAIT_DATA;
      WAIT_DATA: begin
        if (req_ok)           state_d = is_last ? DRAIN : ISSUE;
        else if (timeout_hit) state_d = DRAIN;
      end
      DRAIN:     if (occ_d == '0) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output decode, registered below
  always_comb begin
    rden_d = 1'b0;
    done_d = 1'b0;
    err_d  = err_q;
    case (state_q)
      IDLE:    done_d = start && (burst_len == '0);
      ISSUE:   rden_d = fifo_room;
      DRAIN:   done_d = (occ_d == '0);
      default: ;
    endcase
    if (rd_request && state_q != WAIT_DATA) err_d = 1'b1;
    if (req_ok && !fifo_room)               err_d = 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rden_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      rden_q <= rden_d;
      done_q <= done_d;
      err_q  <= err_d;
      busy_q <= (state_d != IDLE);
    end
  end

  // Burst length latch and issued-word counter
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      len_q    <= '0;
      issued_q <= '0;
    end else if (state_q == IDLE && start && burst_len != '0) begin
      len_q    <= burst_len;
      issued_q <= '0;
    end else if (req_ok) begin
      issued_q <= CNT_W'(issued_q + CNT_W'(1));
    end
  end

  // Capture FIFO pointers and occupancy
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= PTR_W'(wr_ptr_q + PTR_W'(1));
      if (pop)  rd_ptr_q <= PTR_W'(rd_ptr_q + PTR_W'(1));
      occ_q <= occ_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr_q] <= '{last: is_last, addr: rd_addr, data: rd_data};
  end

  // Head entry is gated so the stream reads as zero when nothing is buffered.
  assign head         = mem[rd_ptr_q];
  assign m_valid      = !fifo_empty;
  assign m_data       = m_valid ? head.data : '0;
  assign m_addr       = m_valid ? head.addr : '0;
  assign m_last       = m_valid && head.last;
  assign rden         = rden_q;
  assign done         = done_q;
  assign err_spurious = err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_read_data_collector.sv
// Directed bench for read_data_collector: read-FSM responder, word scoreboard and per-cycle stream checks.
module tb_read_data_collector;

  localparam int unsigned DATA_W = 9;
  localparam int unsigned ADDR_W = 21;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned TMO    = 16;

  logic              sys_clk = 1'b0;
  logic              rst, start, rden, rd_request, m_valid, m_ready, m_last;
  logic              busy, done, err_spurious, timeout;
  logic [CNT_W-1:0]  burst_len;
  logic [DATA_W-1:0] rd_data, m_data;
  logic [ADDR_W-1:0] rd_addr, m_addr;

  read_data_collector #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH),
                        .CNT_W(CNT_W), .TIMEOUT_CYC(TMO)) dut (
    .sys_clk(sys_clk), .rst(rst), .start(start), .burst_len(burst_len),
    .rden(rden), .rd_request(rd_request), .rd_data(rd_data), .rd_addr(rd_addr),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_addr(m_addr),
    .m_last(m_last), .busy(busy), .done(done), .err_spurious(err_spurious),
    .timeout(timeout));

  always #5 sys_clk = ~sys_clk;

  typedef struct { logic [DATA_W-1:0] d; logic [ADDR_W-1:0] a; logic l; } word_t;

  word_t exp_q[$];
  int    nchk = 0, nerr = 0;
  int    rden_total = 0, done_total = 0;
  int    ret_total = 0, spur_done = 0;
  int    spur_req = 0, resp_base = 0, data_base = 0, addr_base = 0;
  int    answer_limit = 1000000;
  bit    expect_done = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  // Read FSM model: answers each rden three cycles later with data_base+i / addr_base+i.
  initial begin
    int cnt;
    logic r;
    cnt = 0;
    rd_request = 1'b0; rd_data = '0; rd_addr = '0;
    forever begin
      @(negedge sys_clk);
      r = rden && !rst;
      @(posedge sys_clk); #1;
      rd_request = 1'b0;
      if (r && (ret_total - resp_base) < answer_limit) cnt = 3;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          rd_request = 1'b1;
          rd_data    = DATA_W'(data_base + (ret_total - resp_base));
          rd_addr    = ADDR_W'(addr_base + (ret_total - resp_base));
          ret_total++;
        end
      end else if (spur_done != spur_req) begin
        rd_request = 1'b1;
        rd_data    = 9'h055;
        rd_addr    = 21'h0abcde;
        spur_done++;
      end
    end
  end

  // Per-cycle stream checker against the expected-word queue.
  initial begin
    bit    stall_prev, pop_emptied;
    word_t held, w;
    stall_prev = 1'b0; pop_emptied = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (rst) begin stall_prev = 1'b0; pop_emptied = 1'b0; continue; end
      if (rden) begin
        chk("one_outstanding", 64'(rden_total - ret_total), 64'd0);
        rden_total++;
      end
      if (done) done_total++;
      if (pop_emptied) chk("done_after_last_pop", 64'(done), 64'd1);
      pop_emptied = 1'b0;
      if (stall_prev) begin
        chk("hold_valid", 64'(m_valid), 64'd1);
        chk("hold_data",  64'(m_data),  64'(held.d));
        chk("hold_addr",  64'(m_addr),  64'(held.a));
        chk("hold_last",  64'(m_last),  64'(held.l));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_word: got data %0h addr %0h, required no word", m_data, m_addr);
        end else begin
          w = exp_q.pop_front();
          chk("word_data", 64'(m_data), 64'(w.d));
          chk("word_addr", 64'(m_addr), 64'(w.a));
          chk("word_last", 64'(m_last), 64'(w.l));
          if (exp_q.size() == 0 && expect_done) pop_emptied = 1'b1;
        end
      end
      stall_prev = m_valid && !m_ready;
      held.d = m_data; held.a = m_addr; held.l = m_last;
    end
  end

  task automatic run_burst(input int len, input int dbase, input int abase, input int nexp);
    word_t w;
    data_base = dbase; addr_base = abase; resp_base = ret_total;
    for (int i = 0; i < nexp; i++) begin
      w.d = DATA_W'(dbase + i); w.a = ADDR_W'(abase + i); w.l = (i == len - 1);
      exp_q.push_back(w);
    end
    burst_len = CNT_W'(len); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clk);
      if (done) break;
    end
    chk(name, 64'(done), 64'd1);
    tick(2);
  endtask

  task automatic wait_returns(input int n, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clk);
      if (ret_total - resp_base >= n) break;
    end
    chk(name, 64'(ret_total - resp_base), 64'(n));
  endtask

  initial begin
    int r0, d0, k, n;
    rst = 1'b1; start = 1'b0; burst_len = '0; m_ready = 1'b1;
    tick(2);
    @(negedge sys_clk);
    chk("rst_outputs", {m_valid, rden, busy, done, err_spurious, timeout, m_last}, 64'd0);
    chk("rst_data", {m_data, m_addr}, 64'd0);
    tick();
    rst = 1'b0;
    tick(2);

    // Basic 4-word burst
    r0 = rden_total;
    run_burst(4, 'h1A0, 'h100, 4);
    for (int i = 0; i < 50; i++) begin @(negedge sys_clk); if (m_valid) break; end
    chk("basic_first_data", 64'(m_data), 64'h1A0);
    chk("basic_first_addr", 64'(m_addr), 64'h000100);
    chk("basic_first_last", 64'(m_last), 64'd0);
    chk("basic_busy", 64'(busy), 64'd1);
    wait_done(100, "basic_done");
    chk("basic_rden", 64'(rden_total - r0), 64'd4);
    chk("basic_drained", 64'(exp_q.size()), 64'd0);
    chk("basic_idle", 64'(busy), 64'd0);

    // Backpressure: 12 words, consumer stalled until the FIFO is full
    m_ready = 1'b0;
    r0 = rden_total; d0 = done_total;
    run_burst(12, 'h0C0, 'h2000, 12);
    wait_returns(8, 200, "bp_fill");
    tick(20);
    chk("bp_rden_stall", 64'(rden_total - r0), 64'd8);
    @(negedge sys_clk);
    chk("bp_head_data", 64'(m_data), 64'h0C0);
    chk("bp_valid", 64'(m_valid), 64'd1);
    tick();
    m_ready = 1'b1;
    wait_done(400, "bp_done");
    chk("bp_rden", 64'(rden_total - r0), 64'd12);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);
    chk("bp_done_once", 64'(done_total - d0), 64'd1);

    // Zero-length burst
    r0 = rden_total; d0 = done_total;
    burst_len = '0; start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge sys_clk);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    tick(3);
    chk("zero_rden", 64'(rden_total - r0), 64'd0);
    chk("zero_done_once", 64'(done_total - d0), 64'd1);

    // start while busy is ignored
    r0 = rden_total; d0 = done_total;
    run_burst(3, 'h150, 'h3000, 3);
    tick(4);
    burst_len = CNT_W'(7); start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(200, "ign_done");
    chk("ign_rden", 64'(rden_total - r0), 64'd3);
    chk("ign_drained", 64'(exp_q.size()), 64'd0);
    chk("ign_done_once", 64'(done_total - d0), 64'd1);

    // Reset after 3 of 5 words
    d0 = done_total;
    run_burst(5, 'h1F0, 'h4000, 5);
    wait_returns(3, 100, "rstb_three");
    tick();
    rst = 1'b1;
    tick(2);
    @(negedge sys_clk);
    chk("rstb_outputs", {m_valid, rden, busy, done, err_spurious, timeout}, 64'd0);
    chk("rstb_no_done", 64'(done_total - d0), 64'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick(2);
    r0 = rden_total;
    run_burst(2, 'h010, 'h5000, 2);
    wait_done(100, "rstb_rerun_done");
    chk("rstb_rerun_rden", 64'(rden_total - r0), 64'd2);
    chk("rstb_rerun_drained", 64'(exp_q.size()), 64'd0);

    // Spurious return while idle
    @(negedge sys_clk);
    chk("spur_before", 64'(err_spurious), 64'd0);
    tick();
    spur_req++;
    tick(3);
    @(negedge sys_clk);
    chk("spur_set", 64'(err_spurious), 64'd1);
    chk("spur_not_pushed", 64'(m_valid), 64'd0);
    tick(10);
    chk("spur_sticky", 64'(err_spurious), 64'd1);

`ifdef READ_TIMEOUT_EN
    // Only the first read is answered; the second must time out
    answer_limit = 1; expect_done = 1'b0;
    r0 = rden_total; d0 = done_total; n = 0; k = 0;
    run_burst(3, 'h1C0, 'h6000, 1);
    for (int i = 0; i < 100 && n < 2; i++) begin @(negedge sys_clk); if (rden) n++; end
    chk("tmo_second_rden", 64'(n), 64'd2);
    for (int i = 0; i < 40; i++) begin @(negedge sys_clk); k++; if (timeout) break; end
    chk("tmo_latency", 64'(k), 64'(TMO));
    wait_done(100, "tmo_done");
    chk("tmo_rden", 64'(rden_total - r0), 64'd2);
    chk("tmo_delivered", 64'(exp_q.size()), 64'd0);
    chk("tmo_done_once", 64'(done_total - d0), 64'd1);
    tick(20);
    chk("tmo_no_more_rden", 64'(rden_total - r0), 64'd2);
    chk("tmo_sticky", 64'(timeout), 64'd1);
    answer_limit = 1000000; expect_done = 1'b1;
`else
    chk("timeout_tied", 64'(timeout), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", nerr, nchk);
    $fatal(1);
  end

endmodule
